systolic_ctrl: RTL and testbench
================================

// Module: systolic_ctrl
// PURPOSE
//  Sequencer for the 2x2 output-stationary systolic_array. On start, reads K operand beats
//  from the A and B operand buffers and sign-extends them. It drives the skewed array inputs,
//  zero-pads unused slots and gates acc_en. It clears the accumulators first, then pulses done
//  once every PE has accumulated its full K-term dot product.
// PARAMETERS
//  IN_W       16        operand width in the buffers (signed)
//  DATA_W     IN_W+1    array operand width; sign-extended from IN_W
//  K_W        8         width of k_len_i; max K = 2**K_W-1
//  PE_LAT     1         cycles from PE input to accumulator update (drain length)
// PORTS
//  clk          in   1         single clock; all logic on posedge
//  rst          in   1         one clock; reset is asynchronous and active-high
//  start_i      in   1         start request, sampled in IDLE only
//  k_len_i      in   K_W       inner dimension K, sampled on accept
//  busy_o       out  1         high from accept until the done cycle inclusive
//  done_o       out  1         one-cycle pulse: array accumulators hold the result
//  rd_en_o      out  1         operand buffer read enable (A and B share the address)
//  rd_addr_o    out  K_W       k index to read
//  a_rd_data_i  in   2*IN_W    {A[1][k],A[0][k]}, valid 1 cycle after rd_en_o
//  b_rd_data_i  in   2*IN_W    {B[k][1],B[k][0]}, valid 1 cycle after rd_en_o
//  acc_clr_o    out  1         one-cycle accumulator clear to the array
//  acc_en_o     out  1         array accumulate enable
//  data_a_0_o   out  DATA_W    row-0 A operand (to PE0)
//  data_a_1_o   out  DATA_W    row-1 A operand (to PE2), skewed by 1 beat
//  data_b_0_o   out  DATA_W    col-0 B operand (to PE0)
//  data_b_1_o   out  DATA_W    col-1 B operand (to PE1), skewed by 1 beat
// BEHAVIOUR
//  Reset: state=IDLE. All outputs are 0, including busy, done, rd_en, rd_addr, acc_clr, acc_en and data_*.
//  FSM: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE. The accept cycle is called T.
//  - IDLE: start_i=1 accepts and latches K=k_len_i.
//    K==0: go to DONE directly (done_o at T+1). No clr, no reads, no acc_en.
//  - CLEAR (T+1): acc_clr_o=1, rd_en_o=1, rd_addr_o=0.
//  - Reads: rd_en_o=1 with rd_addr_o=i at cycle T+1+i, for i=0..K-1. rd_en_o=0 otherwise.
//  - Beat j (j=0..K+1) is driven on the data_* outputs at cycle T+3+j. All data_* are registered.
//      data_a_0=sx(A[0][j]) and data_b_0=sx(B[j][0]) when j<K, else 0.
//      data_a_1=sx(A[1][j-1]) and data_b_1=sx(B[j-1][1]) when 1<=j<=K, else 0.
//    sx() is two's-complement sign extension IN_W->DATA_W. No saturation or rounding.
//  - acc_en_o=1 for cycles T+3 .. T+4+K+PE_LAT inclusive; this is FEED then DRAIN.
//    During DRAIN all data_* are 0, so extra accumulate cycles add 0.
//  - DONE: done_o=1 for exactly one cycle at T+5+K+PE_LAT, then IDLE.
//    busy_o drops the cycle after done. A new start is accepted at the earliest in the cycle after done.
//  Mapping: acc_0=C[0][0], acc_1=C[0][1], acc_2=C[1][0], acc_3=C[1][1], where C=A*B.
//  Counters: one beat counter, width K_W+2, no wrap for K up to 2**K_W-1.
//    rd_addr_o never exceeds K-1.
//  Boundaries:
//  - start_i while busy: ignored and not queued. k_len_i changes while busy: ignored.
//  - start_i held high through DONE: re-accepted in the following IDLE cycle.
//  - rst mid-operation: immediately IDLE with all outputs 0. Array results are undefined.
//  - K=1: reads only addr 0. Beats 0..2 with beat 2 all zero.
// TESTING
//  1. K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start at T -> acc0..3 = 19, 22, 43, 50;
//     done_o exactly at T+8 (PE_LAT=1); acc_en high T+3..T+7.
//  2. K=1, A0=-32768 (0x8000), B0=2 -> data_a_0_o=17'h18000 at T+3;
//     acc0=-65536; done at T+7.
//  3. k_len_i=0 -> done_o at T+1; rd_en, acc_clr and acc_en never assert.
//  4. start_i pulsed at T+4 during K=4 run -> ignored; exactly one done, at T+10; results unaffected.
//  5. rst asserted at T+5 of K=8 run -> same cycle all outputs 0, state IDLE;
//     then a fresh K=2 run gives correct 19/22/43/50.
//  6. Back-to-back: start_i held high, two K=3 runs, all-ones A (value 1), B=2
//     -> acc_clr between runs; every acc=6 after each done.

Source files
------------

// File: rtl/systolic_ctrl.sv
`timescale 1ns/1ps
// Sequencer for a 2x2 output-stationary systolic array: reads K operand beats, skews
// and sign-extends them onto the array inputs, and gates accumulator clear/enable.
module systolic_ctrl #(
    parameter int IN_W   = 16,
    parameter int DATA_W = IN_W + 1,
    parameter int K_W    = 8,
    parameter int PE_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [K_W-1:0]      k_len_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                rd_en_o,
    output logic [K_W-1:0]      rd_addr_o,
    input  logic [2*IN_W-1:0]   a_rd_data_i,
    input  logic [2*IN_W-1:0]   b_rd_data_i,
    output logic                acc_clr_o,
    output logic                acc_en_o,
    output logic [DATA_W-1:0]   data_a_0_o,
    output logic [DATA_W-1:0]   data_a_1_o,
    output logic [DATA_W-1:0]   data_b_0_o,
    output logic [DATA_W-1:0]   data_b_1_o
);

    localparam int CW = K_W + 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    function automatic logic [DATA_W-1:0] sx(input logic [IN_W-1:0] v);
        return {{(DATA_W-IN_W){v[IN_W-1]}}, v};
    endfunction

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [IN_W-1:0]   a_hi_q, b_hi_q;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic [K_W-1:0]    rd_addr_q, rd_addr_d;
    logic              acc_clr_q, acc_clr_d;
    logic              acc_en_q, acc_en_d;
    logic [DATA_W-1:0] da0_q, da0_d, da1_q, da1_d, db0_q, db0_d, db1_q, db1_d;

    logic [CW-1:0]     kx_q, kx_d, done_n, cnt_m1;
    logic              beat0_s, beat1_s;

    assign kx_q   = {2'b00, k_q};
    assign kx_d   = {2'b00, k_d};
    assign done_n = kx_q + CW'(5 + PE_LAT);
    assign cnt_m1 = cnt_d - CW'(1);

    // Next state: cnt_q holds the cycle offset from the accept cycle while busy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    k_d     = k_len_i;
                    cnt_d   = CW'(1);
                    state_d = (k_len_i == K_W'(0)) ? S_DONE : S_CLEAR;
                end else begin
                    cnt_d   = CW'(0);
                end
            end
            S_CLEAR, S_FEED, S_DRAIN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_d == done_n) begin
                    state_d = S_DONE;
                end else if (cnt_d > kx_q + CW'(4)) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_FEED;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = CW'(0);
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CW'(0);
            end
        endcase
    end

    // Control outputs are decoded one cycle early so they leave the block registered.
    always_comb begin
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        acc_clr_d = (state_d == S_CLEAR);
        rd_en_d   = ((state_d == S_CLEAR) || (state_d == S_FEED)) && (cnt_d <= kx_d);
        acc_en_d  = ((state_d == S_FEED) || (state_d == S_DRAIN)) && (cnt_d >= CW'(3));
        if (rd_en_d) begin
            rd_addr_d = cnt_m1[K_W-1:0];
        end else begin
            rd_addr_d = K_W'(0);
        end
    end

    // Row/col 0 take the fresh read beat; row/col 1 take the beat held one cycle earlier.
    always_comb begin
        beat0_s = (state_q == S_FEED) && (cnt_q >= CW'(2)) && (cnt_q <= kx_q + CW'(1));
        beat1_s = (state_q == S_FEED) && (cnt_q >= CW'(3)) && (cnt_q <= kx_q + CW'(2));
        if (beat0_s) begin
            da0_d = sx(a_rd_data_i[IN_W-1:0]);
            db0_d = sx(b_rd_data_i[IN_W-1:0]);
        end else begin
            da0_d = DATA_W'(0);
            db0_d = DATA_W'(0);
        end
        if (beat1_s) begin
            da1_d = sx(a_hi_q);
            db1_d = sx(b_hi_q);
        end else begin
            da1_d = DATA_W'(0);
            db1_d = DATA_W'(0);
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= CW'(0);
            k_q       <= K_W'(0);
            a_hi_q    <= IN_W'(0);
            b_hi_q    <= IN_W'(0);
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= K_W'(0);
            acc_clr_q <= 1'b0;
            acc_en_q  <= 1'b0;
            da0_q     <= DATA_W'(0);
            da1_q     <= DATA_W'(0);
            db0_q     <= DATA_W'(0);
            db1_q     <= DATA_W'(0);
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            a_hi_q    <= a_rd_data_i[2*IN_W-1:IN_W];
            b_hi_q    <= b_rd_data_i[2*IN_W-1:IN_W];
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            acc_clr_q <= acc_clr_d;
            acc_en_q  <= acc_en_d;
            da0_q     <= da0_d;
            da1_q     <= da1_d;
            db0_q     <= db0_d;
            db1_q     <= db1_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign rd_en_o    = rd_en_q;
    assign rd_addr_o  = rd_addr_q;
    assign acc_clr_o  = acc_clr_q;
    assign acc_en_o   = acc_en_q;
    assign data_a_0_o = da0_q;
    assign data_a_1_o = da1_q;
    assign data_b_0_o = db0_q;
    assign data_b_1_o = db1_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
`timescale 1ns/1ps
// Directed bench for systolic_ctrl: operand buffer and 2x2 array models, per-cycle scoreboard.
module tb_systolic_ctrl;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        rd_en;
        logic [7:0]  addr;
        logic        clr;
        logic        en;
        logic [16:0] da0;
        logic [16:0] da1;
        logic [16:0] db0;
        logic [16:0] db1;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [7:0]  k_len_i;
    logic        busy_o, done_o, rd_en_o, acc_clr_o, acc_en_o;
    logic [7:0]  rd_addr_o;
    logic [31:0] a_rd_data_i, b_rd_data_i;
    logic [16:0] data_a_0_o, data_a_1_o, data_b_0_o, data_b_1_o;

    logic [15:0] a0m [256];
    logic [15:0] a1m [256];
    logic [15:0] b0m [256];
    logic [15:0] b1m [256];

    longint      acc_m [4];
    logic [16:0] pa0, pa1, pb0, pb1;

    obs_t        sbq [$];
    int          checks = 0;
    int          errors = 0;

    systolic_ctrl dut (
        .clk(clk), .rst(rst), .start_i(start_i), .k_len_i(k_len_i),
        .busy_o(busy_o), .done_o(done_o), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
        .a_rd_data_i(a_rd_data_i), .b_rd_data_i(b_rd_data_i),
        .acc_clr_o(acc_clr_o), .acc_en_o(acc_en_o),
        .data_a_0_o(data_a_0_o), .data_a_1_o(data_a_1_o),
        .data_b_0_o(data_b_0_o), .data_b_1_o(data_b_1_o)
    );

    always #5 clk = ~clk;

    // Operand buffers: one-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        if (rd_en_o) begin
            a_rd_data_i <= {a1m[rd_addr_o], a0m[rd_addr_o]};
            b_rd_data_i <= {b1m[rd_addr_o], b0m[rd_addr_o]};
        end else begin
            a_rd_data_i <= 32'hDEAD_BEEF;
            b_rd_data_i <= 32'hBEEF_DEAD;
        end
    end

    // 2x2 output-stationary array: A moves right, B moves down.
    always @(posedge clk) begin
        pa0 <= data_a_0_o;
        pa1 <= data_a_1_o;
        pb0 <= data_b_0_o;
        pb1 <= data_b_1_o;
        if (acc_clr_o) begin
            for (int i = 0; i < 4; i++) acc_m[i] <= 64'sd0;
        end else if (acc_en_o) begin
            acc_m[0] <= acc_m[0] + longint'($signed(data_a_0_o)) * longint'($signed(data_b_0_o));
            acc_m[1] <= acc_m[1] + longint'($signed(pa0)) * longint'($signed(data_b_1_o));
            acc_m[2] <= acc_m[2] + longint'($signed(data_a_1_o)) * longint'($signed(pb0));
            acc_m[3] <= acc_m[3] + longint'($signed(pa1)) * longint'($signed(pb1));
        end
    end

    function automatic logic [16:0] sx(input logic [15:0] v);
        return {v[15], v};
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.busy = busy_o; o.done = done_o; o.rd_en = rd_en_o; o.addr = rd_addr_o;
        o.clr = acc_clr_o; o.en = acc_en_o;
        o.da0 = data_a_0_o; o.da1 = data_a_1_o; o.db0 = data_b_0_o; o.db1 = data_b_1_o;
        return o;
    endfunction

    // Expected outputs n cycles after the accept cycle.
    function automatic obs_t expect_at(input int n, input int k);
        obs_t e;
        int d, j;
        e = '0;
        d = (k == 0) ? 1 : k + 6;
        j = n - 3;
        e.busy = (n >= 1 && n <= d);
        e.done = (n == d);
        if (k > 0 && n >= 1 && n <= k) begin
            e.rd_en = 1'b1;
            e.addr  = 8'(n - 1);
        end
        e.clr = (k > 0 && n == 1);
        e.en  = (k > 0 && n >= 3 && n <= k + 5);
        if (k > 0 && j >= 0 && j < k) begin
            e.da0 = sx(a0m[j]);
            e.db0 = sx(b0m[j]);
        end
        if (k > 0 && j >= 1 && j <= k) begin
            e.da1 = sx(a1m[j-1]);
            e.db1 = sx(b1m[j-1]);
        end
        return e;
    endfunction

    task automatic check_obs(input string tag, input obs_t o, input obs_t e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic check_acc(input int k);
        longint c [4];
        for (int i = 0; i < 4; i++) c[i] = 0;
        for (int i = 0; i < k; i++) begin
            c[0] += longint'($signed(a0m[i])) * longint'($signed(b0m[i]));
            c[1] += longint'($signed(a0m[i])) * longint'($signed(b1m[i]));
            c[2] += longint'($signed(a1m[i])) * longint'($signed(b0m[i]));
            c[3] += longint'($signed(a1m[i])) * longint'($signed(b1m[i]));
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            assert (acc_m[i] === c[i]) else begin
                errors++;
                $error("FAIL acc%0d observed=%0d expected=%0d", i, acc_m[i], c[i]);
            end
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            a0m[i] = 16'h0; a1m[i] = 16'h0; b0m[i] = 16'h0; b1m[i] = 16'h0;
        end
    endtask

    task automatic load_t1();
        clear_mem();
        a0m[0] = 16'd1; a0m[1] = 16'd2; a1m[0] = 16'd3; a1m[1] = 16'd4;
        b0m[0] = 16'd5; b0m[1] = 16'd7; b1m[0] = 16'd6; b1m[1] = 16'd8;
    endtask

    // Called at a negedge of an idle cycle; that cycle becomes the accept cycle T.
    task automatic run(input int k, input bit hold, input int pulse_at, input int rst_at);
        obs_t o, e;
        int d;
        d = (k == 0) ? 1 : k + 6;
        checks++;
        assert (busy_o === 1'b0 && done_o === 1'b0) else begin
            errors++;
            $error("FAIL idle_before_start observed=%b%b expected=00", busy_o, done_o);
        end
        start_i = 1'b1;
        k_len_i = 8'(k);
        for (int n = 1; n <= d; n++) sbq.push_back(expect_at(n, k));
        for (int n = 1; n <= d; n++) begin
            @(negedge clk);
            if (n == rst_at) begin
                rst = 1'b1;
                #1;
                check_obs("async_rst", sample(), '0);
                sbq.delete();
                start_i = 1'b0;
                #1 rst = 1'b0;
                return;
            end
            o = sample();
            e = sbq.pop_front();
            check_obs($sformatf("k%0d_cyc%0d", k, n), o, e);
            if (n == 1 && !hold) start_i = 1'b0;
            if (n == pulse_at) begin
                start_i = 1'b1;
                k_len_i = 8'd7;
            end
            if (n == pulse_at + 1) start_i = 1'b0;
        end
        if (k > 0) check_acc(k);
    endtask

    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        k_len_i = 8'd0;
        clear_mem();
        repeat (2) @(negedge clk);
        check_obs("reset_state", sample(), '0);
        rst = 1'b0;
        @(negedge clk);

        // 2x2 product 19/22/43/50.
        load_t1();
        run(2, 1'b0, 0, 0);
        @(negedge clk);

        // Most negative operand sign-extends to 17'h18000.
        clear_mem();
        a0m[0] = 16'h8000; b0m[0] = 16'd2;
        run(1, 1'b0, 0, 0);
        @(negedge clk);

        run(0, 1'b0, 0, 0);
        @(negedge clk);

        // Start pulse mid-run is ignored.
        clear_mem();
        for (int i = 0; i < 4; i++) begin
            a0m[i] = 16'($urandom); a1m[i] = 16'($urandom);
            b0m[i] = 16'($urandom); b1m[i] = 16'($urandom);
        end
        run(4, 1'b0, 4, 0);
        @(negedge clk);

        // Reset mid-run, then a clean run.
        for (int i = 0; i < 8; i++) begin
            a0m[i] = 16'($urandom); a1m[i] = 16'($urandom);
            b0m[i] = 16'($urandom); b1m[i] = 16'($urandom);
        end
        run(8, 1'b0, 0, 5);
        @(negedge clk);
        load_t1();
        run(2, 1'b0, 0, 0);
        @(negedge clk);

        // Back-to-back with start held high.
        clear_mem();
        for (int i = 0; i < 3; i++) begin
            a0m[i] = 16'd1; a1m[i] = 16'd1; b0m[i] = 16'd2; b1m[i] = 16'd2;
        end
        run(3, 1'b1, 0, 0);
        @(negedge clk);
        run(3, 1'b0, 0, 0);
        @(negedge clk);
        check_obs("final_idle", sample(), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
